// File: rtl/aibio_pi_phsel_pkg.sv
// -----------------------------------------------------------------------------
// aibio_pi_phsel_pkg
// Shared types and helpers for the RX DLL phase-interpolator phase-select
// sequencer (aibio_pi_phsel_ctrl and its step divider).
//   - phsel_state_e : sequencer FSM states
//   - NUM_QTR / PH_PER_QTR : geometry of the 16-phase select tree
//   - onehot2()     : 2-bit to 4-bit one-hot decode
//   - ring_step_up(): shortest-direction decision around the 16-phase ring
//   - ring_next()   : code one step closer to the target
// -----------------------------------------------------------------------------
package aibio_pi_phsel_pkg;

   localparam int NUM_QTR    = 4;
   localparam int PH_PER_QTR = 4;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WAIT   = 3'd1,
      ST_STEP   = 3'd2,
      ST_PRESET = 3'd3,
      ST_BREAK  = 3'd4,
      ST_MAKE   = 3'd5
   } phsel_state_e;

   function automatic logic [3:0] onehot2(input logic [1:0] sel);
      return 4'b0001 << sel;
   endfunction

   // Distance is taken modulo 16; 1..8 walks up (the tie at 8 goes up),
   // 9..15 walks down. A zero distance returns 0 but callers never step then.
   function automatic logic ring_step_up(input logic [3:0] tgt,
                                         input logic [3:0] cur);
      logic [3:0] diff;
      diff = tgt - cur;
      return (diff != 4'd0) && (diff <= 4'd8);
   endfunction

   // 4-bit arithmetic gives the 15->0 and 0->15 wrap for free.
   function automatic logic [3:0] ring_next(input logic [3:0] tgt,
                                            input logic [3:0] cur);
      return ring_step_up(tgt, cur) ? cur + 4'd1 : cur - 4'd1;
   endfunction

endpackage

// File: rtl/aibio_pi_phsel_stepdiv.sv
// -----------------------------------------------------------------------------
// aibio_pi_phsel_stepdiv
// Loadable down-counter shared by the step-pacing wait and the
// break-before-make gap. Loading value N makes o_done rise N cycles later
// (immediately when N=0); the counter then parks at zero.
// Ports:
//   i_clk       controller clock
//   i_rstb      asynchronous active-low reset
//   i_load      load i_load_val this cycle (has priority over counting)
//   i_load_val  value to load
//   o_done      counter is at zero
// -----------------------------------------------------------------------------
module aibio_pi_phsel_stepdiv #(
   parameter int W = 4
) (
   input  logic         i_clk,
   input  logic         i_rstb,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   output logic         o_done
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rstb) begin
      if (!i_rstb) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_done = (r_cnt == '0);

endmodule

// File: rtl/aibio_pi_phsel_ctrl.sv
// -----------------------------------------------------------------------------
// aibio_pi_phsel_ctrl
// Sequencer for the RX DLL phase-interpolator phase-select tree (four quarter
// muxes, each a 4:1 stage-1 select plus a tristate stage-2 enable onto a
// shared node). A loaded 4-bit target code is approached one ring step at a
// time, one step every STEP_DIV cycles. Crossing into another quarter is done
// break-before-make: preset the new quarter's stage-1, drop every stage-2
// enable for GAP_CYC cycles, then enable the new quarter.
//
// Optional feature (macro AIBIO_PI_PHSEL_DIRECT_EN):
//   adds i_direct, sampled with i_load; when set the controller jumps straight
//   to the target (one stage-1 update, or one preset/break/make sequence).
//
// Ports:
//   i_clk         controller clock
//   i_rstb        asynchronous active-low reset
//   i_load        load request; accepted only while o_rdy=1
//   i_code        target code {quarter[3:2], phase[1:0]}
//   i_direct      (AIBIO_PI_PHSEL_DIRECT_EN only) jump directly to target
//   o_rdy         idle and able to accept a load
//   o_locked      idle with current code equal to target
//   o_cur_code    code currently applied
//   o_phsel_stg1  per-quarter one-hot stage-1 selects, [4q+3:4q] = quarter q
//   o_phsel_stg2  one-hot (or all-zero) quarter enables
// -----------------------------------------------------------------------------
module aibio_pi_phsel_ctrl
   import aibio_pi_phsel_pkg::*;
#(
   parameter int STEP_DIV = 8,
   parameter int GAP_CYC  = 2
) (
   input  logic        i_clk,
   input  logic        i_rstb,
   input  logic        i_load,
   input  logic [3:0]  i_code,
`ifdef AIBIO_PI_PHSEL_DIRECT_EN
   input  logic        i_direct,
`endif
   output logic        o_rdy,
   output logic        o_locked,
   output logic [3:0]  o_cur_code,
   output logic [15:0] o_phsel_stg1,
   output logic [3:0]  o_phsel_stg2
);

   localparam int CNT_MAX = (STEP_DIV > GAP_CYC) ? STEP_DIV : GAP_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   // WAIT lasts STEP_DIV-1 cycles and BREAK lasts GAP_CYC cycles; the counter
   // reaches zero on the last cycle of the state, hence the -2 / -1.
   localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(STEP_DIV - 2);
   localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYC - 1);

   typedef logic [NUM_QTR-1:0][PH_PER_QTR-1:0] stg1_t;

   phsel_state_e r_state, w_state_nxt;
   logic [3:0]   r_target, w_target_nxt;
   logic [3:0]   r_cur, w_cur_nxt;
   logic [3:0]   r_next, w_next_nxt;
   stg1_t        r_stg1, w_stg1_nxt;
   logic [3:0]   r_stg2, w_stg2_nxt;
   logic         r_direct, w_direct_nxt;
   logic         r_rdy, r_locked;

   logic             w_load_acc;
   logic             w_direct_req;
   logic [3:0]       w_step_code;
   logic             w_idle_nxt;
   logic             w_div_load;
   logic [CNT_W-1:0] w_div_val;
   logic             w_div_done;

`ifdef AIBIO_PI_PHSEL_DIRECT_EN
   assign w_direct_req = i_direct;
`else
   assign w_direct_req = 1'b0;
`endif

   assign w_load_acc  = i_load & r_rdy;
   assign w_step_code = r_direct ? r_target : ring_next(r_target, r_cur);

   aibio_pi_phsel_stepdiv #(
      .W (CNT_W)
   ) u_stepdiv (
      .i_clk      (i_clk),
      .i_rstb     (i_rstb),
      .i_load     (w_div_load),
      .i_load_val (w_div_val),
      .o_done     (w_div_done)
   );

   // NOTE: every signal written here gets a default first, so no path through
   // the case leaves one unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt  = r_state;
      w_target_nxt = r_target;
      w_cur_nxt    = r_cur;
      w_next_nxt   = r_next;
      w_stg1_nxt   = r_stg1;
      w_stg2_nxt   = r_stg2;
      w_direct_nxt = r_direct;
      w_div_load   = 1'b0;
      w_div_val    = WAIT_LD;

      case (r_state)
         ST_IDLE: begin
            if (w_load_acc) begin
               w_target_nxt = i_code;
            end
            // Leaving on the load edge itself keeps load-to-lock at STEP_DIV.
            if (w_target_nxt != r_cur) begin
               w_direct_nxt = w_load_acc & w_direct_req;
               if (w_direct_nxt) begin
                  w_state_nxt = ST_STEP;
               end else begin
                  w_state_nxt = ST_WAIT;
                  w_div_load  = 1'b1;
                  w_div_val   = WAIT_LD;
               end
            end
         end

         ST_WAIT: begin
            if (w_div_done) begin
               w_state_nxt = ST_STEP;
            end
         end

         ST_STEP: begin
            // Same quarter: this is the enabled quarter, a legal in-place move.
            // New quarter: this is the preset, visible while in PRESET.
            w_next_nxt                     = w_step_code;
            w_stg1_nxt[w_step_code[3:2]]   = onehot2(w_step_code[1:0]);
            if (w_step_code[3:2] == r_cur[3:2]) begin
               w_cur_nxt = w_step_code;
               if (w_step_code == r_target) begin
                  w_state_nxt  = ST_IDLE;
                  w_direct_nxt = 1'b0;
               end else begin
                  w_state_nxt = ST_WAIT;
                  w_div_load  = 1'b1;
                  w_div_val   = WAIT_LD;
               end
            end else begin
               w_state_nxt = ST_PRESET;
            end
         end

         ST_PRESET: begin
            w_state_nxt = ST_BREAK;
            w_stg2_nxt  = 4'b0000;
            w_div_load  = 1'b1;
            w_div_val   = GAP_LD;
         end

         ST_BREAK: begin
            if (w_div_done) begin
               w_state_nxt = ST_MAKE;
               w_stg2_nxt  = onehot2(r_next[3:2]);
               w_cur_nxt   = r_next;
            end
         end

         ST_MAKE: begin
            if (r_cur == r_target) begin
               w_state_nxt  = ST_IDLE;
               w_direct_nxt = 1'b0;
            end else begin
               w_state_nxt = ST_WAIT;
               w_div_load  = 1'b1;
               w_div_val   = WAIT_LD;
            end
         end

         default: begin
            w_state_nxt  = ST_IDLE;
            w_direct_nxt = 1'b0;
         end
      endcase

      w_idle_nxt = (w_state_nxt == ST_IDLE) && (w_target_nxt == w_cur_nxt);
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge i_clk or negedge i_rstb) begin
      if (!i_rstb) begin
         r_state  <= ST_IDLE;
         r_target <= 4'd0;
         r_cur    <= 4'd0;
         r_next   <= 4'd0;
         r_stg1   <= {NUM_QTR{4'b0001}};
         r_stg2   <= 4'b0001;
         r_direct <= 1'b0;
         r_rdy    <= 1'b1;
         r_locked <= 1'b1;
      end else begin
         r_state  <= w_state_nxt;
         r_target <= w_target_nxt;
         r_cur    <= w_cur_nxt;
         r_next   <= w_next_nxt;
         r_stg1   <= w_stg1_nxt;
         r_stg2   <= w_stg2_nxt;
         r_direct <= w_direct_nxt;
         r_rdy    <= w_idle_nxt;
         r_locked <= w_idle_nxt;
      end
   end

   assign o_rdy        = r_rdy;
   assign o_locked     = r_locked;
   assign o_cur_code   = r_cur;
   assign o_phsel_stg1 = r_stg1;
   assign o_phsel_stg2 = r_stg2;

endmodule

// File: tb/tb_aibio_pi_phsel_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aibio_pi_phsel_ctrl
// Bench for aibio_pi_phsel_ctrl. A reference model expands each accepted load
// into the full per-cycle timeline of expected outputs; a compare process
// checks the DUT against it on every falling edge. Directed loads pin the
// model with hand-computed values, then a random load stream follows.
// Honours AIBIO_PI_PHSEL_DIRECT_EN (adds i_direct and a direct-jump case).
// -----------------------------------------------------------------------------
module tb_aibio_pi_phsel_ctrl;

   localparam int SD  = 8;
   localparam int GAP = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_load = 1'b0;
   logic [3:0]  i_code = 4'd0;
`ifdef AIBIO_PI_PHSEL_DIRECT_EN
   logic        i_direct = 1'b0;
`endif
   logic        o_rdy, o_locked;
   logic [3:0]  o_cur_code;
   logic [15:0] o_phsel_stg1;
   logic [3:0]  o_phsel_stg2;

   always #5 clk = ~clk;

   aibio_pi_phsel_ctrl #(
      .STEP_DIV (SD),
      .GAP_CYC  (GAP)
   ) dut (
      .i_clk        (clk),
      .i_rstb       (rst_n),
      .i_load       (i_load),
      .i_code       (i_code),
`ifdef AIBIO_PI_PHSEL_DIRECT_EN
      .i_direct     (i_direct),
`endif
      .o_rdy        (o_rdy),
      .o_locked     (o_locked),
      .o_cur_code   (o_cur_code),
      .o_phsel_stg1 (o_phsel_stg1),
      .o_phsel_stg2 (o_phsel_stg2)
   );

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [3:0]  cur;
      logic [15:0] stg1;
      logic [3:0]  stg2;
      logic        rdy;
      logic        locked;
   } snap_t;

   snap_t exp_q[$];
   snap_t m_exp;

   function automatic snap_t rst_snap();
      snap_t s;
      s.cur = 4'h0; s.stg1 = 16'h1111; s.stg2 = 4'b0001;
      s.rdy = 1'b1; s.locked = 1'b1;
      return s;
   endfunction

   // Expand one accepted move into one snapshot per cycle, starting with the
   // cycle right after the load edge and ending with the settled, locked view.
   task automatic plan_move(input logic [3:0] tgt, input bit direct);
      snap_t      s;
      logic [3:0] nxt;
      int         diff;
      int         q;
      s        = m_exp;
      s.rdy    = 1'b0;
      s.locked = 1'b0;
      while (s.cur != tgt) begin
         diff = (int'(tgt) - int'(s.cur) + 16) % 16;
         if (direct)         nxt = tgt;
         else if (diff <= 8) nxt = s.cur + 4'd1;
         else                nxt = s.cur - 4'd1;
         // pacing wait plus the step cycle (direct: step cycle only)
         repeat (direct ? 1 : SD) exp_q.push_back(s);
         q = int'(nxt[3:2]);
         s.stg1[q*4 +: 4] = 4'b0001 << nxt[1:0];
         if (nxt[3:2] != s.cur[3:2]) begin
            exp_q.push_back(s);               // preset, old enable still on
            s.stg2 = 4'b0000;
            repeat (GAP) exp_q.push_back(s);  // nothing drives the node
            s.stg2 = 4'b0001 << nxt[3:2];
            s.cur  = nxt;
            exp_q.push_back(s);               // new quarter enabled, not yet idle
         end else begin
            s.cur = nxt;
         end
      end
      s.rdy    = 1'b1;
      s.locked = 1'b1;
      exp_q.push_back(s);
   endtask

   logic m_dir;
`ifdef AIBIO_PI_PHSEL_DIRECT_EN
   assign m_dir = i_direct;
`else
   assign m_dir = 1'b0;
`endif

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_q.delete();
         m_exp = rst_snap();
      end else if (exp_q.size() != 0) begin
         m_exp = exp_q.pop_front();
      end else if (i_load && m_exp.rdy && (i_code != m_exp.cur)) begin
         plan_move(i_code, m_dir);
         m_exp = exp_q.pop_front();
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (rst_n && chk_en) begin
         check("cur_code", 32'(o_cur_code),   32'(m_exp.cur));
         check("stg1",     32'(o_phsel_stg1), 32'(m_exp.stg1));
         check("stg2",     32'(o_phsel_stg2), 32'(m_exp.stg2));
         check("rdy",      32'(o_rdy),        32'(m_exp.rdy));
         check("locked",   32'(o_locked),     32'(m_exp.locked));
         check("stg2_popcnt_le1", 32'($countones(o_phsel_stg2) <= 1), 32'd1);
         for (int q = 0; q < 4; q++) begin
            check("stg1_nibble_onehot",
                  32'($countones(o_phsel_stg1[q*4 +: 4]) == 1), 32'd1);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic do_load(input logic [3:0] code);
      @(negedge clk);
      i_load = 1'b1;
      i_code = code;
      @(posedge clk);
      #1;
      i_load = 1'b0;
   endtask

`ifdef AIBIO_PI_PHSEL_DIRECT_EN
   task automatic do_load_direct(input logic [3:0] code);
      @(negedge clk);
      i_load   = 1'b1;
      i_code   = code;
      i_direct = 1'b1;
      @(posedge clk);
      #1;
      i_load   = 1'b0;
      i_direct = 1'b0;
   endtask
`endif

   // Counts rising edges until o_locked (bounded) and the cycles seen with
   // all stage-2 enables low.
   task automatic wait_locked(input int max_cyc, output int lat, output int zeros);
      lat   = 0;
      zeros = 0;
      for (int i = 0; i < max_cyc; i++) begin
         @(posedge clk);
         #1;
         lat++;
         if (o_phsel_stg2 == 4'b0000) zeros++;
         if (o_locked) break;
      end
      check("lock_reached", 32'(o_locked), 32'd1);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_cur"},    32'(o_cur_code),   32'h0);
      check({tag, "_stg1"},   32'(o_phsel_stg1), 32'h1111);
      check({tag, "_stg2"},   32'(o_phsel_stg2), 32'h1);
      check({tag, "_rdy"},    32'(o_rdy),        32'h1);
      check({tag, "_locked"}, 32'(o_locked),     32'h1);
   endtask

   // ---------------- main sequence ----------------
   int  lat, zeros;
   bit  seen_break;

   initial begin
      repeat (3) @(negedge clk);
      rst_n  = 1'b1;
      chk_en = 1'b1;
      @(posedge clk);
      #1;
      check_reset_vals("reset");

      // 0 -> 3: three same-quarter steps
      do_load(4'h3);
      wait_locked(10 * SD, lat, zeros);
      check("lat_0to3",   32'(lat),          32'(3 * SD));
      check("cur_0to3",   32'(o_cur_code),   32'h3);
      check("stg1_0to3",  32'(o_phsel_stg1), 32'h1118);
      check("stg2_0to3",  32'(o_phsel_stg2), 32'h1);
      check("gap_0to3",   32'(zeros),        32'd0);

      // 3 -> 4: one crossing, quarter 0 -> quarter 1
      do_load(4'h4);
      wait_locked(10 * SD, lat, zeros);
      check("lat_3to4",   32'(lat),          32'(SD + 2 + GAP));
      check("gap_3to4",   32'(zeros),        32'(GAP));
      check("cur_3to4",   32'(o_cur_code),   32'h4);
      check("stg1_3to4",  32'(o_phsel_stg1), 32'h1118);
      check("stg2_3to4",  32'(o_phsel_stg2), 32'h2);

      // 0 -> F: single down step across the ring wrap
      apply_reset();
      do_load(4'hF);
      wait_locked(10 * SD, lat, zeros);
      check("lat_0toF",   32'(lat),          32'(SD + 2 + GAP));
      check("gap_0toF",   32'(zeros),        32'(GAP));
      check("cur_0toF",   32'(o_cur_code),   32'hF);
      check("stg1_0toF",  32'(o_phsel_stg1), 32'h8111);
      check("stg2_0toF",  32'(o_phsel_stg2), 32'h8);

      // load while busy is dropped
      apply_reset();
      do_load(4'h3);
      repeat (5) @(posedge clk);
      #1;
      check("busy_rdy_low", 32'(o_rdy), 32'd0);
      @(negedge clk);
      i_load = 1'b1;
      i_code = 4'h9;
      @(negedge clk);
      i_load = 1'b0;
      wait_locked(10 * SD, lat, zeros);
      check("busy_load_ignored", 32'(o_cur_code), 32'h3);

      // reset asserted in the middle of BREAK
      do_load(4'h4);
      seen_break = 1'b0;
      for (int i = 0; i < 4 * SD; i++) begin
         @(posedge clk);
         #1;
         if (o_phsel_stg2 == 4'b0000) begin
            seen_break = 1'b1;
            break;
         end
      end
      check("break_reached", 32'(seen_break), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_vals("rst_in_break");
      @(negedge clk);
      rst_n = 1'b1;

`ifdef AIBIO_PI_PHSEL_DIRECT_EN
      // direct jump 0 -> A: one preset/break/make sequence
      do_load_direct(4'hA);
      wait_locked(10 * SD, lat, zeros);
      check("lat_direct",  32'(lat),          32'(3 + GAP));
      check("gap_direct",  32'(zeros),        32'(GAP));
      check("cur_direct",  32'(o_cur_code),   32'hA);
      check("stg1_direct", 32'(o_phsel_stg1), 32'h1411);
      check("stg2_direct", 32'(o_phsel_stg2), 32'h4);
`endif

      // random load stream, loads landing both idle and busy
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         i_load = ($urandom_range(0, 7) == 0);
         i_code = 4'($urandom_range(0, 15));
`ifdef AIBIO_PI_PHSEL_DIRECT_EN
         i_direct = 1'($urandom_range(0, 1));
`endif
      end
      @(negedge clk);
      i_load = 1'b0;
`ifdef AIBIO_PI_PHSEL_DIRECT_EN
      i_direct = 1'b0;
`endif
      wait_locked(20 * SD, lat, zeros);
      repeat (2) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
